// File: rtl/uart_wb_master.sv
// uart_wb_master: serial host command frames -> one Wishbone classic read/write each, reply sent back over serial.
// Latency: Wishbone cycle starts the cycle after the last frame byte; reply starts the cycle after ack or timeout.
// Backpressure: none on the serial input; bytes arriving while a transaction or reply is in progress are dropped.
// Optional: define UART_WB_FRAME_GAP_EN to abandon frames whose bytes are more than FRAME_GAP cycles apart.
module uart_wb_master #(
    parameter int CLKS_PER_BIT = 434,
    parameter int WB_TIMEOUT   = 255,
    parameter int FRAME_GAP    = 10000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rstn_i,
    input  logic        uart_rx_i,
    output logic        uart_tx_o,
    output logic        wbs_cyc_o,
    output logic        wbs_stb_o,
    output logic        wbs_we_o,
    output logic [3:0]  wbs_sel_o,
    output logic [31:0] wbs_adr_o,
    output logic [31:0] wbs_dat_o,
    input  logic [31:0] wbs_dat_i,
    input  logic        wbs_ack_i,
    output logic        busy_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(WB_TIMEOUT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(WB_TIMEOUT - 1);

    // ------------------------------------------------------------------ RX
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    rx_state_e       rx_st_q, rx_st_d;
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CW-1:0]   rx_clk_q, rx_clk_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_vld;

    // Two-flop synchroniser plus one history flop for falling-edge detection
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // RX state register
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            rx_st_q    <= RX_IDLE;
            rx_clk_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_st_q    <= rx_st_d;
            rx_clk_q   <= rx_clk_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // RX bit timing: half-bit start check, then centre sampling LSB first; stop must be high
    always_comb begin
        rx_st_d    = rx_st_q;
        rx_clk_d   = rx_clk_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_vld     = 1'b0;
        unique case (rx_st_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_st_d  = RX_START;
                    rx_clk_d = '0;
                end
            end
            RX_START: begin
                if (rx_clk_q == HALF_LAST) begin
                    rx_clk_d = '0;
                    rx_bit_d = '0;
                    rx_st_d  = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_clk_d = rx_clk_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_clk_q == BIT_LAST) begin
                    rx_clk_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
                end else begin
                    rx_clk_d = rx_clk_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_clk_q == BIT_LAST) begin
                    rx_clk_d = '0;
                    rx_st_d  = RX_IDLE;
                    rx_vld   = rx_sync_q;
                end else begin
                    rx_clk_d = rx_clk_q + CW'(1);
                end
            end
            default: rx_st_d = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------ TX
    logic [9:0]      tx_shift_q, tx_shift_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic [CW-1:0]   tx_clk_q, tx_clk_d;
    logic            tx_act_q, tx_act_d;
    logic            tx_load;
    logic [7:0]      tx_byte;
    logic            tx_done;

    assign tx_done   = tx_act_q && (tx_clk_q == BIT_LAST) && (tx_bit_q == 4'd9);
    assign uart_tx_o = tx_shift_q[0];

    // TX register; all-ones shift register keeps the line idle high
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            tx_shift_q <= '1;
            tx_bit_q   <= '0;
            tx_clk_q   <= '0;
            tx_act_q   <= 1'b0;
        end else begin
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_clk_q   <= tx_clk_d;
            tx_act_q   <= tx_act_d;
        end
    end

    // TX shifter; a load on the final stop-bit cycle chains bytes back-to-back
    always_comb begin
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_clk_d   = tx_clk_q;
        tx_act_d   = tx_act_q;
        if (tx_load) begin
            tx_shift_d = {1'b1, tx_byte, 1'b0};
            tx_bit_d   = '0;
            tx_clk_d   = '0;
            tx_act_d   = 1'b1;
        end else if (tx_act_q) begin
            if (tx_clk_q == BIT_LAST) begin
                tx_clk_d   = '0;
                tx_shift_d = {1'b1, tx_shift_q[9:1]};
                tx_bit_d   = tx_bit_q + 4'd1;
                if (tx_done) tx_act_d = 1'b0;
            end else begin
                tx_clk_d = tx_clk_q + CW'(1);
            end
        end
    end

    // -------------------------------------------------------------- parser
    typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_WB, P_RESP} p_state_e;

    p_state_e        p_st_q, p_st_d;
    logic [1:0]      p_cnt_q, p_cnt_d;
    logic            wr_q, wr_d;
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic [3:0]      sel_q, sel_d;
    logic [31:0]     adr_q, adr_d;
    logic [31:0]     dat_q, dat_d;
    logic [TW-1:0]   to_q, to_d;
    logic [31:0]     resp_q, resp_d;
    logic [1:0]      left_q, left_d;
    logic            start_wb;
`ifdef UART_WB_FRAME_GAP_EN
    localparam int GW = $clog2(FRAME_GAP + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(FRAME_GAP - 1);
    logic [GW-1:0]   gap_q, gap_d;

    // Inter-byte idle counter, only meaningful while a frame is being assembled
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) gap_q <= '0;
        else            gap_q <= gap_d;
    end
`endif

    assign wbs_cyc_o = cyc_q;
    assign wbs_stb_o = cyc_q;
    assign wbs_we_o  = we_q;
    assign wbs_sel_o = sel_q;
    assign wbs_adr_o = adr_q;
    assign wbs_dat_o = dat_q;
    assign busy_o    = (p_st_q != P_IDLE);

    // Parser / bus / response state register
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            p_st_q  <= P_IDLE;
            p_cnt_q <= '0;
            wr_q    <= 1'b0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            to_q    <= '0;
            resp_q  <= '0;
            left_q  <= '0;
        end else begin
            p_st_q  <= p_st_d;
            p_cnt_q <= p_cnt_d;
            wr_q    <= wr_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            to_q    <= to_d;
            resp_q  <= resp_d;
            left_q  <= left_d;
        end
    end

    // Frame assembly, Wishbone handshake with timeout, and reply byte sequencing
    always_comb begin
        p_st_d   = p_st_q;
        p_cnt_d  = p_cnt_q;
        wr_d     = wr_q;
        cyc_d    = cyc_q;
        we_d     = we_q;
        sel_d    = sel_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        to_d     = to_q;
        resp_d   = resp_q;
        left_d   = left_q;
        start_wb = 1'b0;
        tx_load  = 1'b0;
        unique case (p_st_q)
            P_IDLE: begin
                if (rx_vld && (rx_shift_q == 8'h57 || rx_shift_q == 8'h52)) begin
                    p_st_d  = P_ADDR;
                    p_cnt_d = '0;
                    wr_d    = (rx_shift_q == 8'h57);
                end
            end
            P_ADDR: begin
                if (rx_vld) begin
                    adr_d   = {adr_q[23:0], rx_shift_q};
                    p_cnt_d = p_cnt_q + 2'd1;
                    if (p_cnt_q == 2'd3) begin
                        if (wr_q) p_st_d = P_DATA;
                        else      start_wb = 1'b1;
                    end
                end
            end
            P_DATA: begin
                if (rx_vld) begin
                    dat_d   = {dat_q[23:0], rx_shift_q};
                    p_cnt_d = p_cnt_q + 2'd1;
                    if (p_cnt_q == 2'd3) start_wb = 1'b1;
                end
            end
            P_WB: begin
                if (wbs_ack_i) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    p_st_d  = P_RESP;
                    tx_load = 1'b1;
                    resp_d  = wr_q ? {8'h4B, 24'h0} : wbs_dat_i;
                    left_d  = wr_q ? 2'd0 : 2'd3;
                end else if (to_q == TO_LAST) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    p_st_d  = P_RESP;
                    tx_load = 1'b1;
                    resp_d  = {8'h45, 24'h0};
                    left_d  = 2'd0;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            P_RESP: begin
                if (tx_done) begin
                    if (left_q == 2'd0) begin
                        p_st_d = P_IDLE;
                    end else begin
                        resp_d  = {resp_q[23:0], 8'h00};
                        left_d  = left_q - 2'd1;
                        tx_load = 1'b1;
                    end
                end
            end
            default: p_st_d = P_IDLE;
        endcase
        if (start_wb) begin
            p_st_d = P_WB;
            cyc_d  = 1'b1;
            we_d   = wr_q;
            sel_d  = 4'hF;
            to_d   = '0;
        end
`ifdef UART_WB_FRAME_GAP_EN
        gap_d = '0;
        if (p_st_q == P_ADDR || p_st_q == P_DATA) begin
            if (rx_vld) begin
                gap_d = '0;
            end else if (gap_q == GAP_LAST) begin
                p_st_d = P_IDLE;
            end else begin
                gap_d = gap_q + GW'(1);
            end
        end
`endif
        tx_byte = resp_d[31:24];
    end

endmodule

// File: tb/tb_uart_wb_master.sv
`timescale 1ns/1ps
module tb_uart_wb_master;
    localparam int CPB = 16;
    localparam int TO  = 255;
    localparam int GAP = 10000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rx;
    logic        tx;
    logic        cyc, stb, we, busy;
    logic [3:0]  sel;
    logic [31:0] adr, dato;
    logic [31:0] dati = '0;
    logic        ack = 1'b0;

    always #5 clk = ~clk;

    uart_wb_master #(.CLKS_PER_BIT(CPB), .WB_TIMEOUT(TO), .FRAME_GAP(GAP)) dut (
        .wb_clk_i(clk), .wb_rstn_i(rstn), .uart_rx_i(rx), .uart_tx_o(tx),
        .wbs_cyc_o(cyc), .wbs_stb_o(stb), .wbs_we_o(we), .wbs_sel_o(sel),
        .wbs_adr_o(adr), .wbs_dat_o(dato), .wbs_dat_i(dati), .wbs_ack_i(ack),
        .busy_o(busy)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        int          len;
    } wb_exp_t;

    wb_exp_t     exp_wb_q[$];
    logic [7:0]  exp_tx_q[$];
    int          checks = 0;
    int          errors = 0;
    int          epoch = 0;
    int          tx_seen = 0;
    int          busy_cycles = 0;
    int          slv_wait = 0;
    bit          slv_never = 1'b0;
    logic [31:0] slv_rdata = '0;
    int          slv_cnt = 0;
    logic        stb_prev = 1'b0;
    int          stb_len = 0;
    bit          cur_ok = 1'b0;
    wb_exp_t     cur;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave: ack after slv_wait stb cycles (or never); read data is valid only in the ack cycle
    always @(negedge clk) begin
        if (cyc && stb) begin
            if (!slv_never && slv_cnt == slv_wait) begin
                ack  = 1'b1;
                dati = slv_rdata;
            end else begin
                ack  = 1'b0;
                dati = $urandom;
            end
            slv_cnt++;
        end else begin
            ack     = 1'b0;
            dati    = $urandom;
            slv_cnt = 0;
        end
    end

    // Bus monitor: each new strobe is matched against the next expected transaction
    always @(negedge clk) begin
        if (stb && !stb_prev) begin
            if (exp_wb_q.size() == 0) begin
                checks++;
                errors++;
                cur_ok = 1'b0;
                $display("FAIL wb_unexpected: got adr %h expected no cycle", adr);
            end else begin
                cur    = exp_wb_q.pop_front();
                cur_ok = 1'b1;
                check("wb_cyc", 32'(cyc), 32'd1);
                check("wb_we", 32'(we), 32'(cur.we));
                check("wb_sel", 32'(sel), 32'hF);
                check("wb_adr", adr, cur.adr);
                if (cur.we) check("wb_dat", dato, cur.dat);
            end
            stb_len = 1;
        end else if (stb) begin
            stb_len++;
        end else if (stb_prev && cur_ok) begin
            check("wb_stb_len", 32'(stb_len), 32'(cur.len));
        end
        stb_prev = stb;
    end

    always @(negedge clk) if (busy === 1'b1) busy_cycles++;

    // Serial monitor: decodes uart_tx_o and compares each byte with the reply queue
    initial begin
        logic [7:0] b;
        logic       stop;
        int         ep;
        forever begin
            @(negedge tx);
            ep = epoch;
            repeat (CPB / 2) @(negedge clk);
            if (tx == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                stop = tx;
                if (ep == epoch) begin
                    tx_seen++;
                    if (exp_tx_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected: got %h expected nothing", b);
                    end else begin
                        check("tx_byte", 32'(b), 32'(exp_tx_q.pop_front()));
                        check("tx_stop", 32'(stop), 32'd1);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        repeat (CPB) @(negedge clk);
        check("busy_idle", 32'(busy), 32'd0);
        check("wb_pending", 32'(exp_wb_q.size()), 32'd0);
        check("tx_pending", 32'(exp_tx_q.size()), 32'd0);
    endtask

    // Reference model: a frame yields one bus cycle and a reply derived from the command and slave behaviour
    task automatic expect_txn(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d,
                              input int w, input bit never, input logic [31:0] rd);
        wb_exp_t e;
        e.we  = (cmd == 8'h57);
        e.adr = a;
        e.dat = d;
        e.len = never ? TO : w + 1;
        exp_wb_q.push_back(e);
        if (never)     exp_tx_q.push_back(8'h45);
        else if (e.we) exp_tx_q.push_back(8'h4B);
        else for (int i = 3; i >= 0; i--) exp_tx_q.push_back(rd[8*i +: 8]);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
        if (cmd == 8'h57) for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
    endtask

    task automatic run_txn(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d,
                           input int w, input bit never, input logic [31:0] rd);
        bit valid;
        valid     = (cmd == 8'h57) || (cmd == 8'h52);
        slv_wait  = w;
        slv_never = never;
        slv_rdata = rd;
        if (valid) expect_txn(cmd, a, d, w, never, rd);
        send_byte(cmd);
        check("busy_after_cmd", 32'(busy), 32'(valid));
        if (valid) send_frame(cmd, a, d);
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx"}, 32'(tx), 32'd1);
        check({tag, "_cyc"}, 32'(cyc), 32'd0);
        check({tag, "_stb"}, 32'(stb), 32'd0);
        check({tag, "_we"}, 32'(we), 32'd0);
        check({tag, "_sel"}, 32'(sel), 32'd0);
        check({tag, "_adr"}, adr, 32'd0);
        check({tag, "_dat"}, dato, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic reset_mid_resp();
        int n;
        int base;
        n    = 0;
        base = tx_seen;
        slv_wait  = 0;
        slv_never = 1'b0;
        slv_rdata = 32'hA1B2C3D4;
        expect_txn(8'h52, 32'h30000040, 32'h0, 0, 1'b0, 32'hA1B2C3D4);
        send_byte(8'h52);
        send_frame(8'h52, 32'h30000040, 32'h0);
        while (tx_seen == base && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("resp_first_byte", 32'(tx_seen - base), 32'd1);
        repeat (4 * CPB) @(negedge clk);
        #2 rstn = 1'b0;
        epoch++;
        exp_tx_q.delete();
        #1 check_reset_outputs("async_rst");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int          base_busy;
        int          base_tx;
        int          r;
        logic [7:0]  c;
        rstn = 1'b0;
        rx   = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        run_txn(8'h57, 32'h30000004, 32'hDEADBEEF, 2, 1'b0, 32'h0);
        run_txn(8'h52, 32'h30000008, 32'h0, 0, 1'b0, 32'h12345678);
        run_txn(8'h52, 32'h3000000C, 32'h0, 0, 1'b1, 32'h0);

        base_busy = busy_cycles;
        base_tx   = tx_seen;
        run_txn(8'hA5, 32'h0, 32'h0, 0, 1'b0, 32'h0);
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_busy", 32'(busy_cycles - base_busy), 32'd0);
        check("glitch_tx", 32'(tx_seen - base_tx), 32'd0);
        run_txn(8'h57, 32'h30000020, 32'hCAFEF00D, 1, 1'b0, 32'h0);

        reset_mid_resp();
        run_txn(8'h52, 32'h30000044, 32'h0, 1, 1'b0, 32'h0BADF00D);

        for (int k = 0; k < 12; k++) begin
            r = $urandom_range(0, 9);
            c = (r < 5) ? 8'h57 : (r < 9) ? 8'h52 : 8'($urandom);
            run_txn(c, $urandom, $urandom, $urandom_range(0, 3), ($urandom_range(0, 7) == 0), $urandom);
        end

`ifdef UART_WB_FRAME_GAP_EN
        send_byte(8'h57);
        send_byte(8'h30);
        check("gap_busy_high", 32'(busy), 32'd1);
        repeat (GAP + 1) @(negedge clk);
        check("gap_busy_drop", 32'(busy), 32'd0);
        run_txn(8'h57, 32'h30000050, 32'h55AA00FF, 0, 1'b0, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
